period_meter: RTL and testbench

- Measures the period of a slow, asynchronous input waveform (e.g. a divided 1 Hz clock or pattern strobe) in clk_in cycles.
- Sits on the receiving side of a divided clock and confirms that the divided rate matches the expected divisor.
- Reports each period measurement, a lock indication against an expected period, and a missing-edge timeout.

---
 rtl/period_meter.sv | 171 +++++++++++++++++
 tb/tb_period_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow asynchronous input in clk_in
// cycles, tracks lock against EXPECTED +/- TOL and flags a missing edge
// after TIMEOUT cycles with a sticky timeout.
// Optional running min/max of measured periods: define PERIOD_MINMAX_EN.
module period_meter #(
  parameter int unsigned EXPECTED = 100_000_000,
  parameter int unsigned TOL      = 1_000,
  parameter int unsigned TIMEOUT  = 200_000_000,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned CNT_W    = 28
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sig_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int unsigned      LO_LIM  = (EXPECTED > TOL) ? (EXPECTED - TOL) : 0;
  localparam int unsigned      HI_LIM  = EXPECTED + TOL;
  localparam logic [4:0]       RUN_MAX = 5'(LOCK_CNT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             sync_a;
  logic             sync_b;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       run_cnt;
  logic [4:0]       run_inc;
  logic [31:0]      period_ext;
  logic             in_range;
  logic             first_edge;
  logic             meas_done;
  logic             meas_lost;

  // Two-flop synchronizer, previous-value register and registered rising-edge pulse
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_prev <= 1'b0;
      edge_tick <= 1'b0;
    end else begin
      sync_a    <= sig_in;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      edge_tick <= sync_b & ~sync_prev;
    end
  end

  // Free-running cycle counter: restarts at 1 on every edge, saturates at TIMEOUT
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (edge_tick) begin
      cnt <= CNT_ONE;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: an edge always beats a coincident counter saturation
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (edge_tick) state_next = MEASURE;
      MEASURE: if (!edge_tick && (cnt == CNT_MAX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State decodes driving the datapath
  always_comb begin
    first_edge = 1'b0;
    meas_done  = 1'b0;
    meas_lost  = 1'b0;
    case (state)
      IDLE:    first_edge = edge_tick;
      MEASURE: begin
        meas_done = edge_tick;
        meas_lost = !edge_tick && (cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  // Capture the period and pulse period_valid alongside the update
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= meas_done;
      if (meas_done) period_out <= cnt;
    end
  end

  // Sticky timeout: set on a lost edge, cleared by the next first edge
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
    end else if (meas_lost) begin
      timeout <= 1'b1;
    end else if (first_edge) begin
      timeout <= 1'b0;
    end
  end

  assign period_ext = 32'(period_out);
  assign in_range   = (period_ext >= LO_LIM) && (period_ext <= HI_LIM);
  assign run_inc    = {1'b0, run_cnt} + 5'd1;

  // Lock tracking evaluated on the registered period, one cycle after each valid
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt <= '0;
      locked  <= 1'b0;
    end else if (meas_lost) begin
      run_cnt <= '0;
      locked  <= 1'b0;
    end else if (period_valid) begin
      if (in_range) begin
        if ({1'b0, run_cnt} < RUN_MAX) run_cnt <= run_cnt + 4'd1;
        locked <= (run_inc >= RUN_MAX);
      end else begin
        run_cnt <= '0;
        locked  <= 1'b0;
      end
    end
  end

`ifdef PERIOD_MINMAX_EN
  // Running extremes, updated together with period_out
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      period_min <= '1;
      period_max <= '0;
    end else if (meas_done) begin
      if (cnt < period_min) period_min <= cnt;
      if (cnt > period_max) period_max <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table-driven scenarios, hand-written
// corner sequences, and randomized edges checked each cycle against an
// event-level reference model. Define PERIOD_MINMAX_EN to cover min/max.
module tb_period_meter;

  localparam int unsigned EXPECTED = 100;
  localparam int unsigned TOL      = 2;
  localparam int unsigned TIMEOUT  = 250;
  localparam int unsigned LOCK_CNT = 2;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned ALL_ONES = (1 << CNT_W) - 1;

  logic             clk_in  = 1'b0;
  logic             reset_n = 1'b0;
  logic             sig_in  = 1'b0;
  logic             edge_tick;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [CNT_W-1:0] period_out;
`ifdef PERIOD_MINMAX_EN
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
`endif

  period_meter #(
    .EXPECTED(EXPECTED),
    .TOL     (TOL),
    .TIMEOUT (TIMEOUT),
    .LOCK_CNT(LOCK_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .sig_in      (sig_in),
    .edge_tick   (edge_tick),
    .period_out  (period_out),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
`ifdef PERIOD_MINMAX_EN
    ,
    .period_min  (period_min),
    .period_max  (period_max)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on sampled sig_in history and edge-tick cycle indices: a tick is a
  // sampled 0->1 seen two samples ago; a period is the distance between ticks;
  // a lost edge is TIMEOUT cycles without a tick while measuring.
  bit          smp[$];
  bit          m_tick, m_valid, m_meas, m_locked, m_timeout;
  int unsigned m_period, m_min, m_max, m_run, t_last, cyc;

  function automatic bit in_range(input int unsigned p);
    return (p + TOL >= EXPECTED) && (p <= EXPECTED + TOL);
  endfunction

  task automatic model_reset();
    smp.delete();
    repeat (4) smp.push_back(1'b0);
    m_tick = 0; m_valid = 0; m_meas = 0; m_locked = 0; m_timeout = 0;
    m_period = 0; m_min = ALL_ONES; m_max = 0; m_run = 0;
  endtask

  always @(negedge reset_n) model_reset();

  // Monitor captures (actual DUT behaviour, used by the scenario checks)
  int unsigned n_valid = 0, n_tick = 0, cap_period = 0, tick_k = 0, to_k = 0;
  bit          to_prev = 0;

  always @(posedge clk_in) begin
    bit pt, pv;
    if (!reset_n) begin
      model_reset();
    end else begin
      smp.push_front(sig_in);
      void'(smp.pop_back());
      pt = m_tick;
      pv = m_valid;
      m_valid = 0;
      if (pv) begin
        if (in_range(m_period)) begin
          if (m_run < LOCK_CNT) m_run++;
          m_locked = (m_run >= LOCK_CNT);
        end else begin
          m_run = 0;
          m_locked = 0;
        end
      end
      if (pt) begin
        if (m_meas) begin
          m_period = cyc - t_last;
          m_valid  = 1;
          if (m_period < m_min) m_min = m_period;
          if (m_period > m_max) m_max = m_period;
        end else begin
          m_meas = 1;
          m_timeout = 0;
        end
        t_last = cyc;
      end else if (m_meas && (cyc - t_last == TIMEOUT)) begin
        m_timeout = 1;
        m_locked  = 0;
        m_run     = 0;
        m_meas    = 0;
      end
      m_tick = smp[2] && !smp[3];
    end
    #1;
    check("cyc_edge_tick", 32'(edge_tick), 32'(m_tick));
    check("cyc_period_valid", 32'(period_valid), 32'(m_valid));
    check("cyc_period_out", 32'(period_out), m_period);
    check("cyc_locked", 32'(locked), 32'(m_locked));
    check("cyc_timeout", 32'(timeout), 32'(m_timeout));
`ifdef PERIOD_MINMAX_EN
    check("cyc_period_min", 32'(period_min), m_min);
    check("cyc_period_max", 32'(period_max), m_max);
`endif
    if (period_valid) begin
      n_valid++;
      cap_period = 32'(period_out);
    end
    if (edge_tick) begin
      n_tick++;
      tick_k = cyc;
    end
    if (timeout && !to_prev) to_k = cyc;
    to_prev = timeout;
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_zero(input string tag);
    check({tag, "_edge_tick"}, 32'(edge_tick), 0);
    check({tag, "_period_out"}, 32'(period_out), 0);
    check({tag, "_period_valid"}, 32'(period_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
`ifdef PERIOD_MINMAX_EN
    check({tag, "_period_min"}, 32'(period_min), ALL_ONES);
    check({tag, "_period_max"}, 32'(period_max), 0);
`endif
  endtask

  // Rising edge now (at a negedge), next rising edge 'gap' cycles later.
  // Six cycles after the rise, the valid/period/locked it produced are settled.
  task automatic apply_rise(input int unsigned gap, input bit exp_v, input int unsigned exp_p,
                            input bit exp_l, input string tag);
    int unsigned v0, hi;
    v0 = n_valid;
    hi = gap / 2;
    sig_in = 1'b1;
    repeat (6) @(negedge clk_in);
    check({tag, "_valid"}, n_valid - v0, 32'(exp_v));
    if (exp_v) check({tag, "_period"}, cap_period, exp_p);
    check({tag, "_locked"}, 32'(locked), 32'(exp_l));
    repeat (hi - 6) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (gap - hi) @(negedge clk_in);
  endtask

  task automatic wait_timeout(input string tag);
    int unsigned v0;
    v0 = n_valid;
    for (int i = 0; i < 400 && !timeout; i++) @(negedge clk_in);
    check({tag, "_set"}, 32'(timeout), 1);
    // cnt reaches TIMEOUT TIMEOUT cycles after the tick cycle; the flag registers one edge later
    check({tag, "_delay"}, to_k - tick_k, TIMEOUT + 1);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_no_valid"}, n_valid - v0, 0);
  endtask

  typedef struct {
    int unsigned gap;
    bit          exp_v;
    int unsigned exp_p;
    bit          exp_l;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{100, 1'b0,   0, 1'b0};  // first edge: no valid
    tbl[1] = '{100, 1'b1, 100, 1'b0};  // one in-range period
    tbl[2] = '{103, 1'b1, 100, 1'b1};  // second in-range -> locked
    tbl[3] = '{101, 1'b1, 103, 1'b0};  // 103 out of range -> unlock
    tbl[4] = '{101, 1'b1, 101, 1'b0};
    tbl[5] = '{ 20, 1'b1, 101, 1'b1};  // relocked

    model_reset();

    // Reset held while sig_in toggles: all outputs stay cleared
    repeat (2) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      sig_in = ~sig_in;
      repeat (3) @(negedge clk_in);
    end
    check_zero("in_reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_in);
    check("no_tick_after_release", n_tick, 0);

    // Lock / unlock table
    for (int i = 0; i < 6; i++)
      apply_rise(tbl[i].gap, tbl[i].exp_v, tbl[i].exp_p, tbl[i].exp_l, "lock_tbl");

    // Missing edge while locked, then recovery
    wait_timeout("timeout1");
    apply_rise(99, 1'b0, 0, 1'b0, "after_to");
    check("timeout_cleared", 32'(timeout), 0);
    apply_rise(30, 1'b1, 99, 1'b0, "after_to2");

    // Reset 40 cycles into a measurement
    sig_in = 1'b1;
    repeat (20) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (20) @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    apply_rise(100, 1'b0,   0, 1'b0, "post_rst0");
    apply_rise( 98, 1'b1, 100, 1'b0, "post_rst1");
    apply_rise(101, 1'b1,  98, 1'b1, "post_rst2");
    apply_rise( 99, 1'b1, 101, 1'b1, "post_rst3");
    apply_rise( 30, 1'b1,  99, 1'b1, "post_rst4");
`ifdef PERIOD_MINMAX_EN
    check("minmax_min", 32'(period_min), 98);
    check("minmax_max", 32'(period_max), 101);
`endif
    wait_timeout("timeout2");
`ifdef PERIOD_MINMAX_EN
    check("minmax_min_after_to", 32'(period_min), 98);
    check("minmax_max_after_to", 32'(period_max), 101);
`endif

    // Edge coinciding with counter saturation wins; one cycle later loses
    apply_rise(250, 1'b0, 0, 1'b0, "sat_first");
    apply_rise(251, 1'b1, 250, 1'b0, "sat_edge_wins");
    check("sat_no_timeout", 32'(timeout), 0);
    apply_rise(30, 1'b0, 0, 1'b0, "late_edge");
    check("late_edge_timeout_cleared", 32'(timeout), 0);

    // Randomized edges checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      int unsigned r, gap, hw;
      r = $urandom_range(0, 9);
      if (r == 0)      gap = $urandom_range(245, 256);
      else if (r == 1) gap = $urandom_range(2, 20);
      else             gap = $urandom_range(95, 105);
      hw = $urandom_range(1, gap - 1);
      sig_in = 1'b1;
      repeat (hw) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (gap - hw) @(negedge clk_in);
    end
    repeat (300) @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
